uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single `uart_tx` serializer among `NUM_REQ` byte producers. Each accepted byte is latched, optionally preceded by a tag byte that identifies the source channel, and handed to `uart_tx` through its `tx_valid`/`tx_data_in` strobe. Completion is tracked through `tx_busy`. The block sits between the on-chip producers and `uart_tx` inside the top-level wrapper.

---
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one uart_tx serializer among NUM_REQ byte
// producers, optionally prefixing each data byte with a channel tag byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TAG_ENABLE   = 1,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [3:0]             grant_idx,
    output logic                   arb_busy,
    output logic                   tx_err
);

    localparam int unsigned N = NUM_REQ;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT_RISE,
        WAIT_FALL
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [3:0]         last;
    logic [3:0]         winner;
    logic [3:0]         cnt;
    logic [7:0]         hold;
    logic [7:0]         win_data;
    logic [N-1:0]       win_hot;
    logic               found;
    logic               ph;
    logic               accept;
    logic               byte_done;
    logic               timeout;

    // Search last+1, last+2, ... ; last+k spans at most 2N-1, so a wrap is a
    // match against either i or i+N rather than a modulo.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        win_hot  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req_valid[i] &&
                    ((32'(last) + k == i) || (32'(last) + k == i + N))) begin
                    found      = 1'b1;
                    winner     = 4'(i);
                    win_data   = req_data[8*i +: 8];
                    win_hot[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        byte_done  = 1'b0;
        timeout    = 1'b0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (found && !tx_busy) begin
                    accept     = 1'b1;
                    state_next = STROBE;
                    req_ready  = rst_n ? win_hot : '0;
                end
            end
            STROBE: begin
                state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (tx_busy) begin
                    state_next = WAIT_FALL;
                end else if (cnt == 4'(BUSY_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    byte_done = 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (byte_done) begin
            state_next = ph ? IDLE : STROBE;
        end
    end

    // tx_valid/tx_data are loaded on the edge that enters STROBE so both are
    // registered and tx_data holds until the next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            grant_idx <= '0;
            arb_busy  <= 1'b0;
            tx_err    <= 1'b0;
            last      <= 4'(NUM_REQ - 1);
            hold      <= '0;
            ph        <= 1'b0;
            cnt       <= '0;
        end else begin
            tx_valid <= 1'b0;
            if (accept) begin
                hold      <= win_data;
                grant_idx <= winner;
                last      <= winner;
                ph        <= (TAG_ENABLE == 0);
                arb_busy  <= 1'b1;
                tx_valid  <= 1'b1;
                tx_data   <= (TAG_ENABLE != 0) ? {4'hA, winner} : win_data;
            end
            if (state == STROBE) begin
                cnt <= '0;
            end else if (state == WAIT_RISE && !tx_busy && !timeout) begin
                cnt <= cnt + 4'd1;
            end
            if (timeout) begin
                tx_err <= 1'b1;
            end
            if (byte_done) begin
                if (!ph) begin
                    ph       <= 1'b1;
                    tx_valid <= 1'b1;
                    tx_data  <= hold;
                end else begin
                    arb_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of single transfers plus
// hand-written sequences for untagged mode, late requests, timeout and reset.
module tb_uart_tx_arbiter;

    localparam int FRAME = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [3:0]  grant_idx;
    logic        arb_busy;
    logic        tx_err;

    logic [3:0]  v0;
    logic [31:0] d0;
    logic [3:0]  ready0;
    logic        txv0;
    logic [7:0]  txd0;
    logic        busy0;
    logic [3:0]  grant0;
    logic        ab0;
    logic        err0;

    int n_cmp = 0;
    int n_err = 0;

    logic        model_en;
    int          frame_cnt;
    logic [7:0]  log_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .TAG_ENABLE(1), .BUSY_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_idx(grant_idx), .arb_busy(arb_busy), .tx_err(tx_err)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .TAG_ENABLE(0), .BUSY_TIMEOUT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_data(d0),
        .req_ready(ready0), .tx_valid(txv0), .tx_data(txd0),
        .tx_busy(busy0), .grant_idx(grant0), .arb_busy(ab0), .tx_err(err0)
    );

    // uart_tx stand-in: busy for FRAME cycles starting the cycle after a strobe.
    always @(posedge clk) begin
        if (!model_en) begin
            tx_busy   <= 1'b0;
            frame_cnt <= 0;
        end else if (tx_valid) begin
            tx_busy   <= 1'b1;
            frame_cnt <= FRAME;
            log_q.push_back(tx_data);
        end else if (frame_cnt != 0) begin
            frame_cnt <= frame_cnt - 1;
            if (frame_cnt == 1) tx_busy <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_strobe(input string name, input int max_cyc);
        bit seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        check({name, "_strobe_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit idle = 1'b0;
        for (int c = 0; c < max_cyc && !idle; c++) begin
            @(negedge clk);
            if (!arb_busy) idle = 1'b1;
        end
        check({name, "_idle_seen"}, 32'(idle), 32'd1);
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_idx;
        logic [7:0]  exp_tag;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int n, input vec_t v);
        string tag = $sformatf("vec%0d", n);
        @(negedge clk);
        req_valid = v.valid;
        req_data  = v.data;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(v.exp_ready));
        @(negedge clk);
        req_valid = '0;
        check({tag, "_tag_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_tag_byte"}, 32'(tx_data), 32'(v.exp_tag));
        check({tag, "_grant"}, 32'(grant_idx), 32'(v.exp_idx));
        check({tag, "_busy"}, 32'(arb_busy), 32'd1);
        wait_strobe(tag, 40);
        check({tag, "_data_byte"}, 32'(tx_data), 32'(v.exp_data));
        wait_idle(tag, 40);
    endtask

    int         grants[5];
    int         g;
    int         exp_grant[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_log[10] = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12,
                                8'hA3, 8'h13, 8'hA0, 8'h10};
    bit         quiet;
    bit         late_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{4'b0100, 32'h005C_0000, 4'b0100, 4'd2, 8'hA2, 8'h5C};
        vecs[1] = '{4'b1111, 32'h1312_1110, 4'b1000, 4'd3, 8'hA3, 8'h13};
        vecs[2] = '{4'b1111, 32'h2322_2120, 4'b0001, 4'd0, 8'hA0, 8'h20};
        vecs[3] = '{4'b0101, 32'h4433_2211, 4'b0100, 4'd2, 8'hA2, 8'h33};
        vecs[4] = '{4'b0011, 32'h0000_BEEF, 4'b0001, 4'd0, 8'hA0, 8'hEF};
        vecs[5] = '{4'b0001, 32'h0000_00FF, 4'b0001, 4'd0, 8'hA0, 8'hFF};
        vecs[6] = '{4'b1000, 32'h8000_0000, 4'b1000, 4'd3, 8'hA3, 8'h80};
        vecs[7] = '{4'b0110, 32'h00AB_CD00, 4'b0010, 4'd1, 8'hA1, 8'hCD};

        rst_n = 1'b0; model_en = 1'b1;
        req_valid = 4'b1111; req_data = 32'h1312_1110;
        v0 = 4'b1111; d0 = '0; busy0 = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant", 32'(grant_idx), 32'd0);
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_tx_err", 32'(tx_err), 32'd0);
        check("rst_ready0", 32'(ready0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; req_valid = '0; v0 = '0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // untagged instance: single strobe, arb_busy drops after tx_busy falls
        @(negedge clk);
        v0 = 4'b0010; d0 = 32'h0000_FF00;
        #1;
        check("notag_ready", 32'(ready0), 32'b0010);
        @(negedge clk);
        v0 = '0;
        check("notag_valid", 32'(txv0), 32'd1);
        check("notag_byte", 32'(txd0), 32'hFF);
        check("notag_grant", 32'(grant0), 32'd1);
        busy0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("notag_no_strobe", 32'(txv0), 32'd0);
            check("notag_busy_hold", 32'(ab0), 32'd1);
        end
        @(negedge clk);
        busy0 = 1'b0;
        #1;
        check("notag_busy_last", 32'(ab0), 32'd1);
        @(negedge clk);
        check("notag_busy_drop", 32'(ab0), 32'd0);
        check("notag_single", 32'(txv0), 32'd0);
        check("notag_err", 32'(err0), 32'd0);

        // late request from channel 3 while channel 0 is in its data frame
        @(negedge clk);
        req_valid = 4'b0001; req_data = 32'h0000_0042;
        #1;
        check("late_ready0", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        wait_strobe("late", 40);
        repeat (2) @(negedge clk);
        req_valid = 4'b1000; req_data = 32'h3300_0000;
        quiet = 1'b1; late_seen = 1'b0;
        for (int c = 0; c < 40 && !late_seen; c++) begin
            #1;
            if (!arb_busy) late_seen = 1'b1;
            else begin
                if (req_ready != 0) quiet = 1'b0;
                @(negedge clk);
            end
        end
        check("late_no_early_ready", 32'(quiet), 32'd1);
        check("late_idle_seen", 32'(late_seen), 32'd1);
        check("late_ready3", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        check("late_grant", 32'(grant_idx), 32'd3);
        wait_idle("late3", 40);

        // busy timeout with tx_busy stuck low
        model_en = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 4'b0010; req_data = 32'h0000_7700;
        #1;
        check("to_ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        check("to_tag_valid", 32'(tx_valid), 32'd1);
        check("to_tag_byte", 32'(tx_data), 32'hA1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("to_err_low_%0d", i), 32'(tx_err), 32'd0);
        end
        @(negedge clk);
        check("to_err_set", 32'(tx_err), 32'd1);
        check("to_data_valid", 32'(tx_valid), 32'd1);
        check("to_data_byte", 32'(tx_data), 32'h77);
        repeat (4) @(negedge clk);
        check("to_busy_hold", 32'(arb_busy), 32'd1);
        @(negedge clk);
        check("to_busy_drop", 32'(arb_busy), 32'd0);
        check("to_err_sticky", 32'(tx_err), 32'd1);
        model_en = 1'b1;
        @(negedge clk);

        // reset during the data frame's WAIT_FALL, then round-robin from 0
        req_valid = 4'b0100; req_data = 32'h0099_0000;
        wait_strobe("rst_tag", 10);
        req_valid = '0;
        wait_strobe("rst_data", 40);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_grant", 32'(grant_idx), 32'd0);
        check("mid_rst_arb_busy", 32'(arb_busy), 32'd0);
        check("mid_rst_tx_err", 32'(tx_err), 32'd0);
        log_q.delete();
        @(negedge clk);
        rst_n = 1'b1; req_valid = 4'b1111; req_data = 32'h1312_1110;
        #1;
        check("busy_blocks_ready", 32'(req_ready), 32'd0);
        g = 0;
        for (int c = 0; c < 400 && g < 5; c++) begin
            @(negedge clk);
            #1;
            if (req_ready != 0) begin
                check("rr_onehot", 32'($countones(req_ready)), 32'd1);
                for (int b = 0; b < 4; b++) if (req_ready[b]) grants[g] = b;
                g++;
            end
        end
        check("rr_grant_count", 32'(g), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("rr_grant_%0d", i), 32'(grants[i]), 32'(exp_grant[i]));
        @(negedge clk);
        req_valid = '0;
        wait_idle("rr", 60);
        repeat (2) @(negedge clk);
        check("rr_log_len", 32'(log_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < log_q.size(); i++)
            check($sformatf("rr_log_%0d", i), 32'(log_q[i]), 32'(exp_log[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
